multicycle_datapath: RTL and testbench
======================================

# multicycle_datapath

Multi-cycle RV32I execution core: fetches, decodes, executes and retires one instruction every 3–5+ cycles through an internal state machine. It is the parametrised successor to the single-cycle datapath: configurable reset vector and register count (RV32I/RV32E), conditional branches, a ready/request handshake to data memory with wait states, and illegal-instruction detection. It sits between instruction ROM and data RAM in the CPU top level and needs no external controller.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NUM_REGS`, default 32: register count, 32 (RV32I) or 16 (RV32E); any other value is a configuration error.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `instrMemAddr`  out  32  current PC.
- `instrCode`  in  32  instruction word at `instrMemAddr`, valid combinationally.
- `dataReq`  out  1  data-memory request, held until accepted.
- `dataWe`  out  1  1 = store, 0 = load; meaningful only while `dataReq`=1.
- `dataAddr`  out  32  byte address of the access.
- `dataWData`  out  32  store data (rs2).
- `dataReady`  in  1  memory accepts/completes the access this cycle.
- `rData`  in  32  load data, valid when `dataReady`=1 on a load.
- `retire`  out  1  one-cycle pulse on each instruction's last cycle.
- `illegal`  out  1  sticky; set on an illegal instruction, core halts.

## Operation
- Supported: R-type (0110011: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND), I-ALU (0010011: same set minus SUB, shifts use imm[4:0], funct7 checked for SRAI/SRLI/SLLI), LW (0000011, funct3=010), SW (0100011, funct3=010), B-type (1100011: BEQ BNE BLT BGE BLTU BGEU).
- Illegal: any other opcode/funct3/funct7 combination; rs1/rs2/rd ≥ 16 when `NUM_REGS`=16; LW/SW address with bits[1:0]≠0; taken-branch target with bit[1]≠0. Illegal → state HALT, `illegal`=1, no register/memory/PC update, no `retire`, no `dataReq`.
- Register file: `NUM_REGS`×32, cleared to 0 by reset; x0 reads 0, writes to x0 discarded.
- Arithmetic is mod 2^32; shifts use low 5 bits of operand B; SLT/SLTU produce 0 or 1; SRA sign-fills.
- Immediates sign-extended: I {instr[31:20]}, S {instr[31:25],instr[11:7]}, B {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
- States: FETCH → DECODE → EXECUTE → {WB | MEM | FETCH} ; MEM → WB (load) or FETCH (store); WB → FETCH; HALT absorbing.
  - FETCH: IR ← `instrCode`.
  - DECODE: decode, legality check on opcode/fields; A ← rs1, B ← rs2, imm latched.
  - EXECUTE: ALU result latched; address alignment check; branch: compare and retire; PC ← PC+imm if taken else PC+4.
  - MEM: `dataReq`=1, `dataAddr`=ALU result, `dataWData`=B, `dataWe`=store; stays while `dataReady`=0. Store retires on the `dataReady` cycle, PC ← PC+4. Load latches `rData` on `dataReady`.
  - WB: rd ← result (ALU or load data); retire; PC ← PC+4.
- Branch target and PC+4 wrap mod 2^32.

## Timing
- Reset values: `instrMemAddr`=`RESET_PC`, `dataReq`=0, `dataWe`=0, `dataAddr`=0, `dataWData`=0, `retire`=0, `illegal`=0; state FETCH.
- Latency (cycles, W = wait cycles with `dataReady`=0): branch 3; R/I-ALU 4; SW 4+W; LW 5+W.
- `dataAddr`, `dataWData`, `dataWe` stable for the whole time `dataReq`=1; `dataReady` outside MEM ignored.
- `dataReady`=1 in the first MEM cycle → zero wait states.
- PC and register write take effect on the clock edge ending the retire cycle; next FETCH sees the new PC.
- `illegal` asserts the cycle after the detecting state (DECODE or EXECUTE) and stays until reset.
- Reset mid-MEM: `dataReq` drops asynchronously, no write completes, PC=`RESET_PC`, registers cleared.

## Test plan
- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1 → x3=2, x4=0xFFFFFFF8, `retire` every 4 cycles, PC=16.
- SW x3,8(x0) with `dataReady` low 3 cycles → `dataReq` high 4 cycles, `dataAddr`=8, `dataWData`=2, `dataWe`=1, retire on cycle 7; LW x5,8(x0) with `rData`=2 → x5=2.
- BLT x2,x1,-8 at PC=0x20 with x2=-3, x1=5 → taken, PC=0x18 after 3 cycles; BLTU same operands → not taken, PC=0x24.
- ADDI x0,x0,7 then ADD x6,x0,x0 → x6=0; SRAI 0x80000000 by 4 → 0xF8000000; SLTU 1<0xFFFFFFFF → 1.
- NUM_REGS=16, ADD x17,x1,x2 → `illegal`=1, no retire, PC frozen; LW at address 0x6 → `illegal`, `dataReq` never asserts.
- Reset asserted during MEM wait → `dataReq`=0 immediately, PC=`RESET_PC`, all registers 0, execution restarts at FETCH.

Source files
------------

// File: rtl/multicycle_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_datapath_if
// Purpose  : Data-memory request/ready bus between the core and data RAM.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_datapath_if;
  logic        dataReq;
  logic        dataWe;
  logic [31:0] dataAddr;
  logic [31:0] dataWData;
  logic        dataReady;
  logic [31:0] rData;

  modport master (output dataReq, dataWe, dataAddr, dataWData,
                  input  dataReady, rData);
  modport slave  (input  dataReq, dataWe, dataAddr, dataWData,
                  output dataReady, rData);
endinterface
`default_nettype wire

// File: rtl/multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_datapath
// Purpose  : Multi-cycle RV32I/RV32E core (ALU, LW/SW, branches) with a
//            waited data-memory handshake and sticky illegal-instruction halt.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [31:0]                  instrMemAddr,
  input  logic [31:0]                  instrCode,
  multicycle_datapath_if.master        dmem,
  output logic                         retire,
  output logic                         illegal
);
  localparam bit RV32E = (NUM_REGS == 16);
  localparam int AW    = RV32E ? 4 : 5;

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
  logic        illegal_q, illegal_d;
  logic [31:0] rf_q [NUM_REGS];
  logic [31:0] rf_d [NUM_REGS];
  logic        rf_we;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  logic       is_r, is_i, is_lw, is_sw, is_br;
  logic       fields_ok, regs_ok, legal;
  logic [31:0] imm_sel, op_b, alu_res, br_target, pc_plus4, wb_data;
  logic [4:0] shamt;
  logic       alt, take;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  assign is_r  = (opcode == 7'b0110011);
  assign is_i  = (opcode == 7'b0010011);
  assign is_lw = (opcode == 7'b0000011);
  assign is_sw = (opcode == 7'b0100011);
  assign is_br = (opcode == 7'b1100011);

  always_comb begin
    fields_ok = 1'b0;
    if (is_r)
      fields_ok = (funct7 == 7'b0000000) ||
                  (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
    else if (is_i)
      fields_ok = (funct3 == 3'b001) ? (funct7 == 7'b0000000) :
                  (funct3 == 3'b101) ? (funct7 == 7'b0000000 || funct7 == 7'b0100000) :
                  1'b1;
    else if (is_lw || is_sw)
      fields_ok = (funct3 == 3'b010);
    else if (is_br)
      fields_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
  end

  // Only the register fields an instruction actually uses are range-checked.
  assign regs_ok = !RV32E ||
                   !(rs1[4] || ((is_r || is_sw || is_br) && rs2[4]) ||
                     ((is_r || is_i || is_lw) && rd[4]));
  assign legal   = fields_ok && regs_ok;

  assign imm_sel = is_sw ? {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]} :
                   is_br ? {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0} :
                           {{20{ir_q[31]}}, ir_q[31:20]};

  assign op_b  = is_r ? b_q : imm_q;
  assign shamt = op_b[4:0];
  // For I-type only SRAI carries the alternate bit; ADDI never subtracts.
  assign alt   = is_r ? funct7[5] : (funct3 == 3'b101 && funct7[5]);

  always_comb begin
    alu_res = a_q + op_b;
    if (is_r || is_i) begin
      case (funct3)
        3'b000:  alu_res = (is_r && alt) ? (a_q - op_b) : (a_q + op_b);
        3'b001:  alu_res = a_q << shamt;
        3'b010:  alu_res = {31'b0, $signed(a_q) < $signed(op_b)};
        3'b011:  alu_res = {31'b0, a_q < op_b};
        3'b100:  alu_res = a_q ^ op_b;
        3'b101:  alu_res = alt ? 32'($signed(a_q) >>> shamt) : (a_q >> shamt);
        3'b110:  alu_res = a_q | op_b;
        default: alu_res = a_q & op_b;
      endcase
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  take = (a_q == b_q);
      3'b001:  take = (a_q != b_q);
      3'b100:  take = ($signed(a_q) <  $signed(b_q));
      3'b101:  take = ($signed(a_q) >= $signed(b_q));
      3'b110:  take = (a_q <  b_q);
      default: take = (a_q >= b_q);
    endcase
  end

  assign br_target = pc_q + imm_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign wb_data   = is_lw ? mdr_q : alu_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = instrCode;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!legal) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          a_d     = rf_q[rs1[AW-1:0]];
          b_d     = rf_q[rs2[AW-1:0]];
          imm_d   = imm_sel;
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_br) begin
          if (take && br_target[1]) begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end else begin
            retire  = 1'b1;
            pc_d    = take ? br_target : pc_plus4;
            state_d = S_FETCH;
          end
        end else if ((is_lw || is_sw) && alu_res[1:0] != 2'b00) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          alu_d   = alu_res;
          state_d = (is_lw || is_sw) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        if (dmem.dataReady) begin
          if (is_sw) begin
            retire  = 1'b1;
            pc_d    = pc_plus4;
            state_d = S_FETCH;
          end else begin
            mdr_d   = dmem.rData;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        retire  = 1'b1;
        rf_we   = 1'b1;
        pc_d    = pc_plus4;
        state_d = S_FETCH;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    rf_d = rf_q;
    if (rf_we && rd != 5'd0)
      rf_d[rd[AW-1:0]] = wb_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      illegal_q <= illegal_d;
      rf_q      <= rf_d;
    end
  end

  // Request is decoded straight from state so an async reset drops it at once.
  assign instrMemAddr   = pc_q;
  assign dmem.dataReq   = (state_q == S_MEM);
  assign dmem.dataWe    = (state_q == S_MEM) && is_sw;
  assign dmem.dataAddr  = alu_q;
  assign dmem.dataWData = b_q;
  assign illegal        = illegal_q;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_datapath
// Purpose  : Directed vector bench for multicycle_datapath (RV32I and RV32E).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_datapath;
  logic        clk;
  logic        reset;
  logic [31:0] instrMemAddr, instrCode;
  logic        retire, illegal;
  logic [31:0] e_pc, e_instr;
  logic        e_retire, e_illegal;
  int          checks = 0;
  int          errors = 0;
  int          e_ret_cnt, e_req_cnt;

  multicycle_datapath_if dmem ();
  multicycle_datapath_if dmem_e ();

  multicycle_datapath u_dut (
    .clk          (clk),
    .reset        (reset),
    .instrMemAddr (instrMemAddr),
    .instrCode    (instrCode),
    .dmem         (dmem),
    .retire       (retire),
    .illegal      (illegal)
  );

  multicycle_datapath #(.RESET_PC(32'h0000_0100), .NUM_REGS(16)) u_dut_e (
    .clk          (clk),
    .reset        (reset),
    .instrMemAddr (e_pc),
    .instrCode    (e_instr),
    .dmem         (dmem_e),
    .retire       (e_retire),
    .illegal      (e_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_ret_cnt <= 0;
      e_req_cnt <= 0;
    end else begin
      if (e_retire)       e_ret_cnt <= e_ret_cnt + 1;
      if (dmem_e.dataReq) e_req_cnt <= e_req_cnt + 1;
    end
  end

  typedef struct {
    logic [31:0] instr;
    int          waits;
    logic [31:0] rdata;
    logic [31:0] pc0;
    int          lat;
    int          req_n;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc1;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one instruction from its FETCH cycle (called at a negedge) to the
  // negedge after its retire, playing data memory with v.waits wait states.
  task automatic run_vec(input vec_t v, input string tag);
    int          lat = 0;
    int          req_n = 0;
    int          waited = 0;
    logic [31:0] a = '0, wd = '0, pc0;
    logic        we = 1'b0;
    logic        stable = 1'b1;
    instrCode = v.instr;
    pc0 = instrMemAddr;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      if (dmem.dataReq) begin
        if (req_n == 0) begin
          a = dmem.dataAddr; wd = dmem.dataWData; we = dmem.dataWe;
        end else if (a !== dmem.dataAddr || wd !== dmem.dataWData || we !== dmem.dataWe) begin
          stable = 1'b0;
        end
        req_n++;
        dmem.dataReady = (waited >= v.waits);
        if (waited < v.waits) waited++;
        dmem.rData = v.rdata;
      end else begin
        dmem.dataReady = c[0];
        dmem.rData     = 32'hDEAD_BEEF;
      end
      #1;
      if (retire) lat = c;
      @(negedge clk);
    end
    dmem.dataReady = 1'b0;
    check({tag, " pc_before"}, pc0, v.pc0);
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " pc_after"}, instrMemAddr, v.pc1);
    check({tag, " req_cycles"}, 32'(req_n), 32'(v.req_n));
    if (v.req_n != 0) begin
      check({tag, " we"}, {31'b0, we}, {31'b0, v.we});
      check({tag, " addr"}, a, v.addr);
      if (v.we) check({tag, " wdata"}, wd, v.wdata);
      check({tag, " stable"}, {31'b0, stable}, 32'd1);
    end
  endtask

  initial begin
    int   req_seen, ret_seen;
    logic got_req;
    reset = 1'b1;
    instrCode = 32'h0050_0093;
    e_instr   = 32'h0020_88B3;   // ADD x17,x1,x2 : illegal on RV32E
    dmem.dataReady = 1'b0;   dmem.rData = '0;
    dmem_e.dataReady = 1'b0; dmem_e.rData = '0;

    //          instr          wt rdata         pc0    lat req we addr   wdata          pc1
    vecs[0]  = '{32'h00500093, 0, 32'h0,        32'h00, 4, 0, 0, 32'h0,  32'h0,         32'h04}; // ADDI x1,x0,5
    vecs[1]  = '{32'hFFD00113, 0, 32'h0,        32'h04, 4, 0, 0, 32'h0,  32'h0,         32'h08}; // ADDI x2,x0,-3
    vecs[2]  = '{32'h002081B3, 0, 32'h0,        32'h08, 4, 0, 0, 32'h0,  32'h0,         32'h0C}; // ADD x3,x1,x2
    vecs[3]  = '{32'h40110233, 0, 32'h0,        32'h0C, 4, 0, 0, 32'h0,  32'h0,         32'h10}; // SUB x4,x2,x1
    vecs[4]  = '{32'h00302423, 3, 32'h0,        32'h10, 7, 4, 1, 32'h8,  32'h2,         32'h14}; // SW x3,8(x0)
    vecs[5]  = '{32'h00802283, 0, 32'h2,        32'h14, 5, 1, 0, 32'h8,  32'h0,         32'h18}; // LW x5,8(x0)
    vecs[6]  = '{32'h00502623, 0, 32'h0,        32'h18, 4, 1, 1, 32'hC,  32'h2,         32'h1C}; // SW x5,12(x0)
    vecs[7]  = '{32'h00402823, 1, 32'h0,        32'h1C, 5, 2, 1, 32'h10, 32'hFFFFFFF8,  32'h20}; // SW x4,16(x0)
    vecs[8]  = '{32'hFE116CE3, 0, 32'h0,        32'h20, 3, 0, 0, 32'h0,  32'h0,         32'h24}; // BLTU x2,x1,-8
    vecs[9]  = '{32'hFE114CE3, 0, 32'h0,        32'h24, 3, 0, 0, 32'h0,  32'h0,         32'h1C}; // BLT x2,x1,-8
    vecs[10] = '{32'h00700013, 0, 32'h0,        32'h1C, 4, 0, 0, 32'h0,  32'h0,         32'h20}; // ADDI x0,x0,7
    vecs[11] = '{32'h00000333, 0, 32'h0,        32'h20, 4, 0, 0, 32'h0,  32'h0,         32'h24}; // ADD x6,x0,x0
    vecs[12] = '{32'h00002383, 0, 32'h80000000, 32'h24, 5, 1, 0, 32'h0,  32'h0,         32'h28}; // LW x7,0(x0)
    vecs[13] = '{32'h4043D413, 0, 32'h0,        32'h28, 4, 0, 0, 32'h0,  32'h0,         32'h2C}; // SRAI x8,x7,4
    vecs[14] = '{32'h0020B4B3, 0, 32'h0,        32'h2C, 4, 0, 0, 32'h0,  32'h0,         32'h30}; // SLTU x9,x1,x2
    vecs[15] = '{32'h00602023, 0, 32'h0,        32'h30, 4, 1, 1, 32'h0,  32'h0,         32'h34}; // SW x6,0(x0)
    vecs[16] = '{32'h00802223, 0, 32'h0,        32'h34, 4, 1, 1, 32'h4,  32'hF8000000,  32'h38}; // SW x8,4(x0)
    vecs[17] = '{32'h00902023, 0, 32'h0,        32'h38, 4, 1, 1, 32'h0,  32'h1,         32'h3C}; // SW x9,0(x0)

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst pc",      instrMemAddr, 32'h0);
    check("rst dataReq", {31'b0, dmem.dataReq}, 32'd0);
    check("rst dataWe",  {31'b0, dmem.dataWe}, 32'd0);
    check("rst addr",    dmem.dataAddr, 32'h0);
    check("rst wdata",   dmem.dataWData, 32'h0);
    check("rst retire",  {31'b0, retire}, 32'd0);
    check("rst illegal", {31'b0, illegal}, 32'd0);
    check("rst e pc",    e_pc, 32'h100);

    for (int i = 0; i < 18; i++)
      run_vec(vecs[i], $sformatf("v%0d", i));

    // RV32E core has been sitting on ADD x17 since reset.
    check("e illegal",  {31'b0, e_illegal}, 32'd1);
    check("e pc",       e_pc, 32'h100);
    check("e retires",  32'(e_ret_cnt), 32'd0);
    check("e requests", 32'(e_req_cnt), 32'd0);

    // Misaligned LW x5,6(x0) at 0x3C with dataReady offered throughout.
    instrCode = 32'h0060_2283;
    req_seen = 0; ret_seen = 0;
    for (int c = 1; c <= 10; c++) begin
      dmem.dataReady = 1'b1;
      #1;
      if (dmem.dataReq) req_seen++;
      if (retire)       ret_seen++;
      if (c == 3) check("misalign illegal early", {31'b0, illegal}, 32'd0);
      if (c == 4) check("misalign illegal set",   {31'b0, illegal}, 32'd1);
      @(negedge clk);
    end
    dmem.dataReady = 1'b0;
    check("misalign pc",      instrMemAddr, 32'h3C);
    check("misalign req",     32'(req_seen), 32'd0);
    check("misalign retire",  32'(ret_seen), 32'd0);
    check("misalign sticky",  {31'b0, illegal}, 32'd1);

    // Reset releases the halt; then reset again in the middle of a MEM wait.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    e_instr = 32'h0010_0793;   // ADDI x15,x0,1 : legal on RV32E
    check("reset clears illegal", {31'b0, illegal}, 32'd0);
    check("reset pc", instrMemAddr, 32'h0);
    instrCode = 32'h0010_2023; // SW x1,0(x0), never acknowledged
    got_req = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (c == 4) got_req = dmem.dataReq;
      @(negedge clk);
    end
    check("midmem req active", {31'b0, got_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midmem req drop", {31'b0, dmem.dataReq}, 32'd0);
    check("midmem pc",       instrMemAddr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    // x1 was 5 before reset; SW x1,4(x0) must now store 0.
    run_vec('{32'h00102223, 0, 32'h0, 32'h0, 4, 1, 1, 32'h4, 32'h0, 32'h4}, "post_reset");
    check("e legal no illegal", {31'b0, e_illegal}, 32'd0);
    check("e legal retired", {31'b0, (e_ret_cnt > 0)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
